uart_rx_core: RTL
=================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CHAR_LENGTH, default 8, giving the maximum character width and the width of rx_data.
REQ-002 SHALL have port pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port areset, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to pclk.
REQ-005 SHALL have port baudrate_divisor, input, 16 bits: pclk cycles per oversample tick; 0 is treated as 1.
REQ-006 SHALL have port oversampling_bits, input, 4 bits: ticks per bit time; legal values are 2, 4, 6 and 8.
REQ-007 SHALL have port uart_type, input, 4 bits: data bits per character; legal values are 5 to 8.
REQ-008 SHALL have port stop_bit, input, 2 bits: 1 = one stop bit, 0 = one-and-half, 2 = two.
REQ-009 SHALL have ports parity_en and parity_type, input, 1 bit each: enable parity; parity_type 0 = even, 1 = odd.
REQ-010 SHALL have port msb_first, input, 1 bit: 1 = first data bit received is the MSB.
REQ-011 SHALL have port rx_data, output, CHAR_LENGTH bits: received character, right-aligned, unused upper bits 0.
REQ-012 SHALL have ports rx_valid (output) and rx_ready (input), 1 bit each: character handshake.
REQ-013 SHALL have ports parity_err and framing_err, output, 1 bit each: status qualified by rx_valid.
REQ-014 SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a completed character is dropped.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
REQ-017 SHALL generate a tick every max(baudrate_divisor,1) pclk cycles; the divisor counter is cleared on start detection.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-019 IDLE: on a synchronized 1->0 edge with legal oversampling_bits and uart_type, SHALL latch all config inputs and go to START; illegal config keeps the FSM in IDLE.
REQ-020 Config input changes after latching SHALL have no effect until the next start detection.
REQ-021 START: after oversampling_bits/2 ticks, SHALL sample rx; 0 -> DATA; 1 -> IDLE (false start), with no output and no error.
REQ-022 DATA: SHALL sample one bit every oversampling_bits ticks, uart_type bits in total; then go to PARITY if parity_en, else to STOP.
REQ-023 SHALL shift the first data bit into bit 0 when msb_first=0, and into bit uart_type-1 when msb_first=1.
REQ-024 PARITY: SHALL sample after oversampling_bits ticks; parity_err is set when the XOR of the data bits and the parity bit is not equal to parity_type.
REQ-025 STOP: SHALL sample each stop bit at mid-bit, oversampling_bits ticks apart; framing_err is set if any sampled stop bit is 0.
REQ-026 Character completion SHALL occur at the last stop sample; for stop_bit=0 it occurs oversampling_bits/2 ticks after the first stop sample; the FSM then returns to IDLE.
REQ-027 rx_valid SHALL assert on the cycle after completion; rx_data, parity_err and framing_err SHALL stay stable until rx_valid && rx_ready.
REQ-028 rx_valid SHALL deassert on the cycle after a rx_valid && rx_ready handshake.
REQ-029 If completion occurs while rx_valid && !rx_ready, SHALL keep the old character, drop the new one, and pulse overrun_err.
REQ-030 If completion coincides with rx_valid && rx_ready, SHALL load the new character with no overrun.
REQ-031 stop_bit=3 SHALL be treated as one stop bit.

Reset
REQ-032 When areset=0, SHALL asynchronously force: FSM to IDLE, counters to 0, synchronizer flops to 1, rx_data to 0, and rx_valid, parity_err, framing_err, overrun_err and busy to 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial character; after release, reception resumes only on a fresh 1->0 edge.

Verification
REQ-034 Divisor 2, oversampling 4, 8N1, LSB first, frame for 0xA5 -> rx_data=0xA5, no errors, rx_valid held until rx_ready.
REQ-035 7 data bits, even parity, msb_first=1, 0x41 with wrong parity bit -> rx_data=0x41, parity_err=1; with correct parity bit -> parity_err=0.
REQ-036 5 data bits, stop_bit=2, second stop bit driven 0 -> framing_err=1; false start (low for fewer than 2 ticks, oversampling 4) -> no rx_valid, busy returns to 0.
REQ-037 Two back-to-back 8N1 characters with rx_ready=0 -> first character retained, overrun_err pulses once; repeat with rx_ready=1 at completion -> second character loaded, no overrun.
REQ-038 Reset pulse mid-DATA, then a new frame for 0x3C -> all outputs 0 during reset; rx_data=0x3C with no errors after the new frame.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop input synchronizer, oversampling tick generator,
// start/data/parity/stop FSM, and a one-deep output register with a
// valid/ready handshake and overrun detection.
module uart_rx_core #(
  parameter int CHAR_LENGTH = 8
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   rx,
  input  logic [15:0]            baudrate_divisor,
  input  logic [3:0]             oversampling_bits,
  input  logic [3:0]             uart_type,
  input  logic [1:0]             stop_bit,
  input  logic                   parity_en,
  input  logic                   parity_type,
  input  logic                   msb_first,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   framing_err,
  output logic                   overrun_err,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state;

  // Synchronizer and start-edge detection
  logic       rx_meta;
  logic       rx_sync;
  logic       rx_prev;
  logic [1:0] sync_fill;
  logic       start_edge;

  // Configuration captured at start detection
  logic [15:0] div_lim;
  logic [3:0]  os_cfg;
  logic [3:0]  type_cfg;
  logic [1:0]  stop_cfg;
  logic        par_en_cfg;
  logic        par_type_cfg;
  logic        msb_cfg;

  // Timing and frame accumulation
  logic [15:0]            div_cnt;
  logic [3:0]             tick_cnt;
  logic [3:0]             bit_cnt;
  logic                   stop_phase;
  logic [CHAR_LENGTH-1:0] data_acc;
  logic                   par_acc;
  logic                   par_bad;
  logic                   frm_acc;

  logic       os_ok;
  logic       type_ok;
  logic       cfg_ok;
  logic       tick;
  logic [3:0] half_os;
  logic       half_last;
  logic       full_last;
  logic [3:0] bit_idx;
  logic       single_stop;
  logic       two_stops;
  logic       complete;
  logic       final_frm;

  // Synchronize rx. sync_fill marks when rx_sync holds a real line sample
  // rather than its reset value, so a line that is already low when reset
  // is released is not mistaken for a start edge.
  // NOTE: sequential state is always assigned with <=, so every flop in a
  // block sees the pre-edge values of the others, as the hardware does.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= rx_sync & sync_fill[1];
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  assign os_ok   = (oversampling_bits == 4'd2) || (oversampling_bits == 4'd4) ||
                   (oversampling_bits == 4'd6) || (oversampling_bits == 4'd8);
  assign type_ok = (uart_type >= 4'd5) && (uart_type <= 4'd8) &&
                   (32'(uart_type) <= CHAR_LENGTH);
  assign cfg_ok  = os_ok && type_ok;

  // Tick generator: held at zero while idle, so it restarts on start detection
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      div_cnt <= 16'd0;
    end else if (state == S_IDLE || div_cnt == div_lim - 16'd1) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign tick      = (state != S_IDLE) && (div_cnt == div_lim - 16'd1);
  assign half_os   = {1'b0, os_cfg[3:1]};
  assign half_last = (tick_cnt == half_os - 4'd1);
  assign full_last = (tick_cnt == os_cfg - 4'd1);
  assign bit_idx   = msb_cfg ? (type_cfg - 4'd1 - bit_cnt) : bit_cnt;

  // stop_bit 3 behaves like 1; 0 is one-and-a-half, 2 is two
  assign two_stops   = (stop_cfg == 2'd2);
  assign single_stop = (stop_cfg == 2'd1) || (stop_cfg == 2'd3);

  // Last stop event: the only stop sample for one stop bit, otherwise the
  // second phase (a half-bit wait for 1.5, a second sample for 2).
  assign complete = tick && (state == S_STOP) &&
                    ((!stop_phase && full_last && single_stop) ||
                     (stop_phase && ((stop_cfg == 2'd0) ? half_last : full_last)));

  // Framing status including the sample taken on the completing tick, if any
  assign final_frm = frm_acc | (~rx_sync & (stop_phase ? two_stops : 1'b1));

  // Receive FSM: frame timing, bit capture and error accumulation
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      div_lim      <= 16'd1;
      os_cfg       <= 4'd0;
      type_cfg     <= 4'd0;
      stop_cfg     <= 2'd0;
      par_en_cfg   <= 1'b0;
      par_type_cfg <= 1'b0;
      msb_cfg      <= 1'b0;
      tick_cnt     <= 4'd0;
      bit_cnt      <= 4'd0;
      stop_phase   <= 1'b0;
      data_acc     <= '0;
      par_acc      <= 1'b0;
      par_bad      <= 1'b0;
      frm_acc      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge && cfg_ok) begin
            div_lim      <= (baudrate_divisor == 16'd0) ? 16'd1 : baudrate_divisor;
            os_cfg       <= oversampling_bits;
            type_cfg     <= uart_type;
            stop_cfg     <= stop_bit;
            par_en_cfg   <= parity_en;
            par_type_cfg <= parity_type;
            msb_cfg      <= msb_first;
            tick_cnt     <= 4'd0;
            bit_cnt      <= 4'd0;
            stop_phase   <= 1'b0;
            data_acc     <= '0;
            par_acc      <= 1'b0;
            par_bad      <= 1'b0;
            frm_acc      <= 1'b0;
            state        <= S_START;
            busy         <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            if (half_last) begin
              tick_cnt <= 4'd0;
              if (rx_sync) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (full_last) begin
              tick_cnt <= 4'd0;
              for (int i = 0; i < CHAR_LENGTH; i++) begin
                if (bit_idx == 4'(i)) data_acc[i] <= rx_sync;
              end
              par_acc <= par_acc ^ rx_sync;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == type_cfg - 4'd1) begin
                state <= par_en_cfg ? S_PARITY : S_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            if (full_last) begin
              tick_cnt <= 4'd0;
              par_bad  <= ((par_acc ^ rx_sync) != par_type_cfg);
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            if (complete) begin
              tick_cnt <= 4'd0;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else if (!stop_phase && full_last) begin
              frm_acc    <= frm_acc | ~rx_sync;
              stop_phase <= 1'b1;
              tick_cnt   <= 4'd0;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: hold the character until accepted, drop on overrun
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data     <= data_acc;
          parity_err  <= par_bad;
          framing_err <= final_frm;
          rx_valid    <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
